// File: rtl/func7_bist_ctrl.sv
// Exhaustive 128-vector self-test sweeper for a 7-input combinational unit.
// Samples the unit output after SETTLE cycles and builds a ones count plus a CRC-16 signature.
module func7_bist_ctrl #(
  parameter int unsigned SETTLE      = 1,
  parameter logic [7:0]  EXPECT_ONES = 8'd79,
  parameter logic [15:0] EXPECT_SIG  = 16'h0000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_start,
  input  logic        i_abort,
  input  logic        i_dut_y,
  output logic [6:0]  o_vec,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_pass,
  output logic [7:0]  o_ones_count,
  output logic [15:0] o_signature,
  output logic [1:0]  o_state
);

  // Handshake: i_start and i_abort are plain levels sampled on each rising edge.
  // i_start is honoured only in IDLE/DONE, i_abort only while busy (APPLY/SAMPLE).
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_APPLY  = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

  state_t      r_state, w_state;
  logic [6:0]  r_vec, w_vec;
  logic [3:0]  r_cnt, w_cnt;
  logic [7:0]  r_ones, w_ones;
  logic [15:0] r_sig, w_sig;
  logic        r_busy, w_busy;
  logic        r_done, w_done;
  logic        r_pass, w_pass;

  logic [7:0]  w_ones_inc;
  logic        w_fb;
  logic [15:0] w_sig_upd;

  assign w_ones_inc = r_ones + {7'd0, i_dut_y};
  assign w_fb       = r_sig[15] ^ i_dut_y;
  assign w_sig_upd  = {r_sig[14:0], 1'b0} ^ (w_fb ? 16'h1021 : 16'h0000);

  always_comb begin
    w_state = r_state;
    w_vec   = r_vec;
    w_cnt   = r_cnt;
    w_ones  = r_ones;
    w_sig   = r_sig;
    w_busy  = r_busy;
    w_done  = r_done;
    w_pass  = r_pass;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (i_start) begin
          w_state = ST_APPLY;
          w_vec   = '0;
          w_cnt   = '0;
          w_ones  = '0;
          w_sig   = 16'hFFFF;
          w_busy  = 1'b1;
          w_done  = 1'b0;
          w_pass  = 1'b0;
        end
      end
      ST_APPLY: begin
        if (i_abort) begin
          w_state = ST_IDLE;
          w_vec   = '0;
          w_cnt   = '0;
          w_ones  = '0;
          w_sig   = 16'hFFFF;
          w_busy  = 1'b0;
          w_done  = 1'b0;
          w_pass  = 1'b0;
        end else if (r_cnt == SETTLE_LAST) begin
          w_state = ST_SAMPLE;
          w_cnt   = '0;
        end else begin
          w_cnt = r_cnt + 4'd1;
        end
      end
      ST_SAMPLE: begin
        if (i_abort) begin
          w_state = ST_IDLE;
          w_vec   = '0;
          w_cnt   = '0;
          w_ones  = '0;
          w_sig   = 16'hFFFF;
          w_busy  = 1'b0;
          w_done  = 1'b0;
          w_pass  = 1'b0;
        end else begin
          w_ones = w_ones_inc;
          w_sig  = w_sig_upd;
          // Last vector: hold vec at 127 and judge on the freshly updated accumulators.
          if (r_vec == 7'd127) begin
            w_state = ST_DONE;
            w_busy  = 1'b0;
            w_done  = 1'b1;
            w_pass  = (w_ones_inc == EXPECT_ONES) && (w_sig_upd == EXPECT_SIG);
          end else begin
            w_state = ST_APPLY;
            w_vec   = r_vec + 7'd1;
          end
        end
      end
      default: w_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
      r_vec   <= '0;
      r_cnt   <= '0;
      r_ones  <= '0;
      r_sig   <= 16'hFFFF;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_pass  <= 1'b0;
    end else begin
      r_state <= w_state;
      r_vec   <= w_vec;
      r_cnt   <= w_cnt;
      r_ones  <= w_ones;
      r_sig   <= w_sig;
      r_busy  <= w_busy;
      r_done  <= w_done;
      r_pass  <= w_pass;
    end
  end

  assign o_vec        = r_vec;
  assign o_busy       = r_busy;
  assign o_done       = r_done;
  assign o_pass       = r_pass;
  assign o_ones_count = r_ones;
  assign o_signature  = r_sig;
  assign o_state      = r_state;

endmodule

// File: tb/tb_func7_bist_ctrl.sv
// Directed bench for func7_bist_ctrl: one SETTLE=1 instance with a combinational unit,
// one SETTLE=3 instance (wrong EXPECT_ONES) driven by a unit with two cycles of delay.
module tb_func7_bist_ctrl;

  localparam logic [1:0] S_IDLE = 2'd0, S_APPLY = 2'd1, S_SAMPLE = 2'd2, S_DONE = 2'd3;

  function automatic logic ref_f(input logic [6:0] v);
    return (v[6] & v[5] & v[4]) | ~v[3] | (~v[2] & v[1] & v[0]);
  endfunction

  function automatic logic model_y(input int m, input logic [6:0] v);
    if (m == 0) return ref_f(v);
    return (m == 2);
  endfunction

  function automatic logic [15:0] crc_step(input logic [15:0] s, input logic y);
    logic fb;
    fb = s[15] ^ y;
    return {s[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
  endfunction

  function automatic logic [15:0] model_sig(input int m);
    logic [15:0] s;
    s = 16'hFFFF;
    for (int v = 0; v < 128; v++) s = crc_step(s, model_y(m, 7'(v)));
    return s;
  endfunction

  localparam logic [15:0] REF_SIG = model_sig(0);

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst1, start1, abort1, y1;
  logic [6:0]  vec1;
  logic        busy1, done1, pass1;
  logic [7:0]  ones1;
  logic [15:0] sig1;
  logic [1:0]  st1;
  int          mode;

  logic        rst3, start3, abort3, y3;
  logic [6:0]  vec3;
  logic        busy3, done3, pass3;
  logic [7:0]  ones3;
  logic [15:0] sig3;
  logic [1:0]  st3;
  logic        d1_q, d2_q;

  assign y1 = model_y(mode, vec1);

  always @(posedge clk) begin
    d1_q <= ref_f(vec3);
    d2_q <= d1_q;
  end
  assign y3 = d2_q;

  func7_bist_ctrl #(.SETTLE(1), .EXPECT_ONES(8'd79), .EXPECT_SIG(REF_SIG)) u_dut1 (
    .i_clk(clk), .i_rst(rst1), .i_start(start1), .i_abort(abort1), .i_dut_y(y1),
    .o_vec(vec1), .o_busy(busy1), .o_done(done1), .o_pass(pass1),
    .o_ones_count(ones1), .o_signature(sig1), .o_state(st1)
  );

  func7_bist_ctrl #(.SETTLE(3), .EXPECT_ONES(8'd80), .EXPECT_SIG(REF_SIG)) u_dut3 (
    .i_clk(clk), .i_rst(rst3), .i_start(start3), .i_abort(abort3), .i_dut_y(y3),
    .o_vec(vec3), .o_busy(busy3), .o_done(done3), .o_pass(pass3),
    .o_ones_count(ones3), .o_signature(sig3), .o_state(st3)
  );

  // scoreboard
  int n_checks = 0;
  int n_pass   = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    exp_q.push_back(exp);
    if (obs === exp_q.pop_front()) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_reset1(input string t);
    check({t, "_state"}, 32'(st1), 32'(S_IDLE));
    check({t, "_vec"}, 32'(vec1), 32'd0);
    check({t, "_busy"}, 32'(busy1), 32'd0);
    check({t, "_done"}, 32'(done1), 32'd0);
    check({t, "_pass"}, 32'(pass1), 32'd0);
    check({t, "_ones"}, 32'(ones1), 32'd0);
    check({t, "_sig"}, 32'(sig1), 32'hFFFF);
  endtask

  task automatic expect_reset3(input string t);
    check({t, "_state"}, 32'(st3), 32'(S_IDLE));
    check({t, "_vec"}, 32'(vec3), 32'd0);
    check({t, "_busy"}, 32'(busy3), 32'd0);
    check({t, "_done"}, 32'(done3), 32'd0);
    check({t, "_pass"}, 32'(pass3), 32'd0);
    check({t, "_ones"}, 32'(ones3), 32'd0);
    check({t, "_sig"}, 32'(sig3), 32'hFFFF);
  endtask

  task automatic start_sweep1();
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
  endtask

  task automatic start_sweep3();
    start3 = 1'b1;
    tick();
    start3 = 1'b0;
  endtask

  // Counts edges after the start edge until done; optionally pulses start mid-sweep.
  task automatic wait_done1(input int pulse_at, output int edges, output int verr);
    logic [6:0] prev;
    edges = 0;
    verr  = 0;
    prev  = vec1;
    while (done1 !== 1'b1 && edges < 3000) begin
      if (pulse_at >= 0) start1 = (edges == pulse_at);
      tick();
      edges++;
      if (!(vec1 == prev || vec1 == prev + 7'd1)) verr++;
      prev = vec1;
    end
    if (pulse_at >= 0) start1 = 1'b0;
  endtask

  // Vector changes must land only on every 4th edge after the start edge.
  task automatic wait_done3(output int edges, output int verr);
    logic [6:0] prev;
    edges = 0;
    verr  = 0;
    prev  = vec3;
    while (done3 !== 1'b1 && edges < 5000) begin
      tick();
      edges++;
      if (vec3 != prev && ((edges % 4) != 0 || vec3 != prev + 7'd1)) verr++;
      prev = vec3;
    end
  endtask

  int edges, verr, cnt;

  initial begin
    mode = 0;
    rst1 = 1'b1; start1 = 1'b0; abort1 = 1'b0;
    rst3 = 1'b1; start3 = 1'b0; abort3 = 1'b0;
    repeat (3) tick();
    expect_reset1("rst1");
    expect_reset3("rst3");
    rst1 = 1'b0;
    rst3 = 1'b0;
    repeat (4) tick();
    expect_reset1("post_rst1");

    // reference function sweep
    start_sweep1();
    check("ref_busy_rise", 32'(busy1), 32'd1);
    check("ref_state_apply", 32'(st1), 32'(S_APPLY));
    wait_done1(-1, edges, verr);
    check("ref_edges", 32'(edges), 32'd256);
    check("ref_vec_walk", 32'(verr), 32'd0);
    check("ref_ones", 32'(ones1), 32'd79);
    check("ref_sig", 32'(sig1), 32'(REF_SIG));
    check("ref_pass", 32'(pass1), 32'd1);
    check("ref_vec_end", 32'(vec1), 32'd127);
    check("ref_busy_fall", 32'(busy1), 32'd0);
    repeat (3) tick();
    check("done_hold", 32'(done1), 32'd1);
    check("done_hold_pass", 32'(pass1), 32'd1);
    check("done_hold_ones", 32'(ones1), 32'd79);
    check("done_hold_state", 32'(st1), 32'(S_DONE));
    abort1 = 1'b1;
    tick();
    abort1 = 1'b0;
    check("abort_in_done_done", 32'(done1), 32'd1);
    check("abort_in_done_sig", 32'(sig1), 32'(REF_SIG));

    // constant zero
    mode = 1;
    start_sweep1();
    check("c0_done_clear", 32'(done1), 32'd0);
    check("c0_pass_clear", 32'(pass1), 32'd0);
    check("c0_ones_clear", 32'(ones1), 32'd0);
    wait_done1(-1, edges, verr);
    check("c0_edges", 32'(edges), 32'd256);
    check("c0_ones", 32'(ones1), 32'd0);
    check("c0_sig", 32'(sig1), 32'(model_sig(1)));
    check("c0_pass", 32'(pass1), 32'd0);

    // constant one: 128 must not wrap to 0
    mode = 2;
    start_sweep1();
    wait_done1(-1, edges, verr);
    check("c1_edges", 32'(edges), 32'd256);
    check("c1_ones", 32'(ones1), 32'd128);
    check("c1_sig", 32'(sig1), 32'(model_sig(2)));
    check("c1_pass", 32'(pass1), 32'd0);

    // start pulsed mid-sweep is ignored
    mode = 0;
    start_sweep1();
    wait_done1(50, edges, verr);
    check("midstart_edges", 32'(edges), 32'd256);
    check("midstart_walk", 32'(verr), 32'd0);
    check("midstart_pass", 32'(pass1), 32'd1);

    // start held high through DONE restarts on the next edge
    start1 = 1'b1;
    tick();
    wait_done1(-1, edges, verr);
    check("held_edges", 32'(edges), 32'd256);
    tick();
    check("held_restart_state", 32'(st1), 32'(S_APPLY));
    check("held_restart_busy", 32'(busy1), 32'd1);
    check("held_restart_done", 32'(done1), 32'd0);
    check("held_restart_pass", 32'(pass1), 32'd0);
    check("held_restart_ones", 32'(ones1), 32'd0);
    start1 = 1'b0;
    wait_done1(-1, edges, verr);
    check("held_second_edges", 32'(edges), 32'd256);
    check("held_second_pass", 32'(pass1), 32'd1);

    // abort in APPLY at vec 40
    start_sweep1();
    cnt = 0;
    while (!(vec1 == 7'd40 && st1 == S_APPLY) && cnt < 1000) begin
      tick();
      cnt++;
    end
    check("abort_reach_40", 32'(cnt < 1000), 32'd1);
    abort1 = 1'b1;
    tick();
    abort1 = 1'b0;
    expect_reset1("abort40");
    repeat (5) tick();
    check("abort_stay_idle", 32'(st1), 32'(S_IDLE));
    check("abort_stay_busy", 32'(busy1), 32'd0);
    start_sweep1();
    wait_done1(-1, edges, verr);
    check("post_abort_edges", 32'(edges), 32'd256);
    check("post_abort_ones", 32'(ones1), 32'd79);
    check("post_abort_pass", 32'(pass1), 32'd1);

    // start+abort while busy aborts, start+abort in IDLE starts
    start_sweep1();
    repeat (7) tick();
    start1 = 1'b1;
    abort1 = 1'b1;
    tick();
    start1 = 1'b0;
    abort1 = 1'b0;
    expect_reset1("sa_busy");
    start1 = 1'b1;
    abort1 = 1'b1;
    tick();
    start1 = 1'b0;
    abort1 = 1'b0;
    check("sa_idle_state", 32'(st1), 32'(S_APPLY));
    check("sa_idle_busy", 32'(busy1), 32'd1);
    wait_done1(-1, edges, verr);
    check("sa_idle_edges", 32'(edges), 32'd256);
    check("sa_idle_pass", 32'(pass1), 32'd1);

    // SETTLE=3 with a 2-cycle unit
    start_sweep3();
    check("s3_busy", 32'(busy3), 32'd1);
    wait_done3(edges, verr);
    check("s3_edges", 32'(edges), 32'd512);
    check("s3_vec_4cyc", 32'(verr), 32'd0);
    check("s3_ones", 32'(ones3), 32'd79);
    check("s3_sig", 32'(sig3), 32'(REF_SIG));
    check("s3_pass_wrong_ones", 32'(pass3), 32'd0);

    // async reset mid-cycle in SAMPLE at vec 100
    start_sweep3();
    cnt = 0;
    while (!(vec3 == 7'd100 && st3 == S_SAMPLE) && cnt < 1000) begin
      tick();
      cnt++;
    end
    check("arst_reach_100", 32'(cnt < 1000), 32'd1);
    #2;
    rst3 = 1'b1;
    #1;
    expect_reset3("arst_async");
    tick();
    rst3 = 1'b0;
    repeat (10) tick();
    expect_reset3("arst_quiet");
    start_sweep3();
    wait_done3(edges, verr);
    check("arst_resweep_edges", 32'(edges), 32'd512);
    check("arst_resweep_done", 32'(done3), 32'd1);
    check("arst_resweep_ones", 32'(ones3), 32'd79);
    check("arst_resweep_pass", 32'(pass3), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
